sweep_seq_ctrl: RTL and testbench

Frequency-sweep sequencer that drives the tuning-word (`freq`) and load-strobe (`add`) inputs of the synth's sine generator. On a start command it presents a start frequency, then steps it toward a stop frequency by a fixed increment. Each frequency is held for a programmable number of clocks. It sits between the control/register logic and sinus_gen, and owns the generator's tuning interface.

---
 rtl/sweep_seq_ctrl_if.sv | 29 ++
 rtl/sweep_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sweep_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_seq_ctrl_if.sv
// Tuning-interface bundle between the control logic and the sweep sequencer.
// The master side supplies the sweep configuration and commands. The slave
// side (the sequencer) returns the tuning word, the load strobe and the status.
interface sweep_seq_ctrl_if #(
    parameter int FW = 18,
    parameter int DW = 16
);
    logic          start;
    logic          abort;
    logic          repeat_en;
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_stop;
    logic [FW-1:0] f_step;
    logic [DW-1:0] dwell;
    logic [FW-1:0] freq;
    logic          add;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, repeat_en, f_start, f_stop, f_step, dwell,
        input  freq, add, busy, done
    );

    modport slave (
        input  start, abort, repeat_en, f_start, f_stop, f_step, dwell,
        output freq, add, busy, done
    );
endinterface

// File: rtl/sweep_seq_ctrl.sv
// Frequency-sweep sequencer for the sine generator's tuning port.
// An accepted start latches a shadow copy of the configuration. The sequencer
// then emits f_start and steps toward f_stop, clamping at f_stop. Each word is
// held for max(dwell,1) clocks. Every new word is qualified by a one-cycle add
// strobe. All outputs come straight from registers.
module sweep_seq_ctrl #(
    parameter int FW = 18,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sweep_seq_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2,
        S_STEP  = 2'd3
    } state_t;

    localparam logic [DW-1:0] DW_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] DW_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [FW-1:0] FW_ZERO = {FW{1'b0}};

    state_t        r_state;
    logic [FW-1:0] r_f_start;
    logic [FW-1:0] r_f_stop;
    logic [FW-1:0] r_f_step;
    logic [DW-1:0] r_dwell_m1;
    logic          r_repeat;
    logic          r_dir_up;
    logic [DW-1:0] r_cnt;
    logic [FW-1:0] r_freq;
    logic          r_add;
    logic          r_busy;
    logic          r_done;

    logic [DW-1:0] w_dwell_m1_in;
    logic [FW-1:0] w_next_freq;

    // Next tuning word, saturated at the stop word in either direction.
    // A zero step also lands directly on the stop word.
    function automatic logic [FW-1:0] f_next_freq(
        input logic [FW-1:0] cur,
        input logic [FW-1:0] step,
        input logic [FW-1:0] stop,
        input logic          up
    );
        logic [FW:0] nxt;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, step};
            if ((step == FW_ZERO) || nxt[FW] || (nxt[FW-1:0] > stop)) begin
                return stop;
            end else begin
                return nxt[FW-1:0];
            end
        end else begin
            nxt = {1'b0, cur} - {1'b0, step};
            if ((step == FW_ZERO) || nxt[FW] || (nxt[FW-1:0] < stop)) begin
                return stop;
            end else begin
                return nxt[FW-1:0];
            end
        end
    endfunction

    // Dwell reload value from the live input: a dwell of 0 behaves like 1.
    always_comb begin
        w_dwell_m1_in = DW_ZERO;
        if (bus.dwell == DW_ZERO) begin
            w_dwell_m1_in = DW_ZERO;
        end else begin
            w_dwell_m1_in = bus.dwell - DW_ONE;
        end
    end

    // Candidate next word from the current word and the shadow configuration.
    always_comb begin
        w_next_freq = f_next_freq(r_freq, r_f_step, r_f_stop, r_dir_up);
    end

    // Sweep FSM: sequences states and produces every registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_f_start  <= FW_ZERO;
            r_f_stop   <= FW_ZERO;
            r_f_step   <= FW_ZERO;
            r_dwell_m1 <= DW_ZERO;
            r_repeat   <= 1'b0;
            r_dir_up   <= 1'b0;
            r_cnt      <= DW_ZERO;
            r_freq     <= FW_ZERO;
            r_add      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_add  <= 1'b0;
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        r_f_start  <= bus.f_start;
                        r_f_stop   <= bus.f_stop;
                        r_f_step   <= bus.f_step;
                        r_dwell_m1 <= w_dwell_m1_in;
                        r_repeat   <= bus.repeat_en;
                        r_dir_up   <= (bus.f_stop >= bus.f_start);
                        r_cnt      <= w_dwell_m1_in;
                        r_freq     <= bus.f_start;
                        r_add      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOAD;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                // LOAD and STEP are the strobe cycles; they count dwell like DWELL.
                S_LOAD, S_DWELL, S_STEP: begin
                    if (bus.abort) begin
                        r_add   <= 1'b0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt != DW_ZERO) begin
                        r_cnt   <= r_cnt - DW_ONE;
                        r_add   <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= S_DWELL;
                    end else if (r_freq == r_f_stop) begin
                        r_done <= 1'b1;
                        if (r_repeat) begin
                            r_freq  <= r_f_start;
                            r_add   <= 1'b1;
                            r_cnt   <= r_dwell_m1;
                            r_state <= S_LOAD;
                        end else begin
                            r_add   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_freq  <= w_next_freq;
                        r_add   <= 1'b1;
                        r_done  <= 1'b0;
                        r_cnt   <= r_dwell_m1;
                        r_state <= S_STEP;
                    end
                end
                default: begin
                    r_add   <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.freq = r_freq;
    assign bus.add  = r_add;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_sweep_seq_ctrl.sv
// Directed self-checking bench for sweep_seq_ctrl.
// Cycle k is the k-th clock period after the one in which start is high.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sweep_seq_ctrl;
    localparam int FW = 18;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    sweep_seq_ctrl_if #(.FW(FW), .DW(DW)) bus ();

    sweep_seq_ctrl #(.FW(FW), .DW(DW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int fs, input int fe, input int st, input int dw, input logic rep);
        bus.f_start   = FW'(fs);
        bus.f_stop    = FW'(fe);
        bus.f_step    = FW'(st);
        bus.dwell     = DW'(dw);
        bus.repeat_en = rep;
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        tick;
        bus.start = 1'b1;
        tick;
        n_tests++;
        if ({bus.add, bus.busy, bus.done, bus.freq} !== {1'b0, 1'b0, 1'b0, {FW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset got add=%0b busy=%0b done=%0b freq=%0d, required all 0",
                     bus.add, bus.busy, bus.done, bus.freq);
        end
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick;
    endtask

    task automatic test_up_sweep;
        logic e_add, e_busy, e_done;
        int   e_freq;
        set_cfg(1000, 1300, 100, 4, 1'b0);
        bus.start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
            e_add  = (k <= 13) && ((k - 1) % 4 == 0);
            e_freq = (k < 5) ? 1000 : (k < 9) ? 1100 : (k < 13) ? 1200 : 1300;
            e_busy = (k < 17);
            e_done = (k == 17);
            n_tests++;
            if ({bus.add, bus.busy, bus.done, bus.freq} !== {e_add, e_busy, e_done, FW'(e_freq)}) begin
                n_fail++;
                $display("FAIL up_sweep k=%0d got add=%0b busy=%0b done=%0b freq=%0d, required add=%0b busy=%0b done=%0b freq=%0d",
                         k, bus.add, bus.busy, bus.done, bus.freq, e_add, e_busy, e_done, e_freq);
            end
        end
    endtask

    task automatic test_start_abort_idle;
        set_cfg(77, 99, 1, 1, 1'b0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick;
            n_tests++;
            if ({bus.add, bus.busy, bus.done, bus.freq} !== {1'b0, 1'b0, 1'b0, FW'(1300)}) begin
                n_fail++;
                $display("FAIL start_abort_idle k=%0d got add=%0b busy=%0b done=%0b freq=%0d, required 0/0/0 freq=1300",
                         k, bus.add, bus.busy, bus.done, bus.freq);
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick;
    endtask

    task automatic test_down_clamp;
        logic e_add, e_busy, e_done;
        int   e_freq;
        set_cfg(1000, 750, 100, 2, 1'b0);
        bus.start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
            e_add  = (k <= 7) && ((k - 1) % 2 == 0);
            e_freq = (k < 3) ? 1000 : (k < 5) ? 900 : (k < 7) ? 800 : 750;
            e_busy = (k < 9);
            e_done = (k == 9);
            n_tests++;
            if ({bus.add, bus.busy, bus.done, bus.freq} !== {e_add, e_busy, e_done, FW'(e_freq)}) begin
                n_fail++;
                $display("FAIL down_clamp k=%0d got add=%0b busy=%0b done=%0b freq=%0d, required add=%0b busy=%0b done=%0b freq=%0d",
                         k, bus.add, bus.busy, bus.done, bus.freq, e_add, e_busy, e_done, e_freq);
            end
        end
    endtask

    task automatic test_overflow;
        logic e_add, e_busy, e_done;
        int   e_freq;
        set_cfg(262000, 262143, 200, 0, 1'b0);
        bus.start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
            e_add  = (k <= 2);
            e_freq = (k == 1) ? 262000 : 262143;
            e_busy = (k < 3);
            e_done = (k == 3);
            n_tests++;
            if ({bus.add, bus.busy, bus.done, bus.freq} !== {e_add, e_busy, e_done, FW'(e_freq)}) begin
                n_fail++;
                $display("FAIL overflow k=%0d got add=%0b busy=%0b done=%0b freq=%0d, required add=%0b busy=%0b done=%0b freq=%0d",
                         k, bus.add, bus.busy, bus.done, bus.freq, e_add, e_busy, e_done, e_freq);
            end
        end
    endtask

    task automatic test_step_zero;
        logic e_add, e_busy, e_done;
        int   e_freq;
        set_cfg(100, 500, 0, 2, 1'b0);
        bus.start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
            e_add  = (k == 1) || (k == 3);
            e_freq = (k < 3) ? 100 : 500;
            e_busy = (k < 5);
            e_done = (k == 5);
            n_tests++;
            if ({bus.add, bus.busy, bus.done, bus.freq} !== {e_add, e_busy, e_done, FW'(e_freq)}) begin
                n_fail++;
                $display("FAIL step_zero k=%0d got add=%0b busy=%0b done=%0b freq=%0d, required add=%0b busy=%0b done=%0b freq=%0d",
                         k, bus.add, bus.busy, bus.done, bus.freq, e_add, e_busy, e_done, e_freq);
            end
        end
    endtask

    task automatic test_equal_start_stop;
        logic e_add, e_busy, e_done;
        set_cfg(42, 42, 5, 3, 1'b0);
        bus.start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
            e_add  = (k == 1);
            e_busy = (k < 4);
            e_done = (k == 4);
            n_tests++;
            if ({bus.add, bus.busy, bus.done, bus.freq} !== {e_add, e_busy, e_done, FW'(42)}) begin
                n_fail++;
                $display("FAIL equal_start_stop k=%0d got add=%0b busy=%0b done=%0b freq=%0d, required add=%0b busy=%0b done=%0b freq=42",
                         k, bus.add, bus.busy, bus.done, bus.freq, e_add, e_busy, e_done);
            end
        end
    endtask

    task automatic test_repeat;
        logic e_add, e_busy, e_done;
        int   e_freq;
        set_cfg(10, 30, 10, 3, 1'b1);
        bus.start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
            e_add  = ((k - 1) % 3 == 0);
            e_freq = 10 + 10 * (((k - 1) / 3) % 3);
            e_busy = 1'b1;
            e_done = (k == 10) || (k == 19);
            n_tests++;
            if ({bus.add, bus.busy, bus.done, bus.freq} !== {e_add, e_busy, e_done, FW'(e_freq)}) begin
                n_fail++;
                $display("FAIL repeat k=%0d got add=%0b busy=%0b done=%0b freq=%0d, required add=%0b busy=%0b done=%0b freq=%0d",
                         k, bus.add, bus.busy, bus.done, bus.freq, e_add, e_busy, e_done, e_freq);
            end
        end
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        n_tests++;
        if ({bus.add, bus.busy, bus.done, bus.freq} !== {1'b0, 1'b0, 1'b0, FW'(10)}) begin
            n_fail++;
            $display("FAIL repeat_abort got add=%0b busy=%0b done=%0b freq=%0d, required 0/0/0 freq=10",
                     bus.add, bus.busy, bus.done, bus.freq);
        end
        tick;
    endtask

    task automatic test_abort_ignored_start;
        logic e_add, e_busy, e_done;
        int   e_freq;
        set_cfg(1000, 1300, 100, 4, 1'b0);
        bus.start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
            if (k == 7) bus.start = 1'b0;
            if (k == 11) bus.abort = 1'b0;
            e_add  = (k <= 9) && ((k - 1) % 4 == 0);
            e_freq = (k < 5) ? 1000 : (k < 9) ? 1100 : 1200;
            e_busy = (k < 11);
            e_done = 1'b0;
            n_tests++;
            if ({bus.add, bus.busy, bus.done, bus.freq} !== {e_add, e_busy, e_done, FW'(e_freq)}) begin
                n_fail++;
                $display("FAIL abort_ignored_start k=%0d got add=%0b busy=%0b done=%0b freq=%0d, required add=%0b busy=%0b done=%0b freq=%0d",
                         k, bus.add, bus.busy, bus.done, bus.freq, e_add, e_busy, e_done, e_freq);
            end
            if (k == 6) begin
                set_cfg(5, 9, 1, 1, 1'b1);
                bus.start = 1'b1;
            end
            if (k == 10) bus.abort = 1'b1;
        end
    endtask

    task automatic test_async_reset;
        logic e_add, e_busy, e_done;
        int   e_freq;
        set_cfg(1000, 1300, 100, 4, 1'b0);
        bus.start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.add, bus.busy, bus.done, bus.freq} !== {1'b0, 1'b0, 1'b0, {FW{1'b0}}}) begin
            n_fail++;
            $display("FAIL async_reset got add=%0b busy=%0b done=%0b freq=%0d, required all 0",
                     bus.add, bus.busy, bus.done, bus.freq);
        end
        @(negedge clk);
        rst = 1'b0;
        tick;
        n_tests++;
        if ({bus.add, bus.busy, bus.done, bus.freq} !== {1'b0, 1'b0, 1'b0, {FW{1'b0}}}) begin
            n_fail++;
            $display("FAIL post_reset_idle got add=%0b busy=%0b done=%0b freq=%0d, required all 0",
                     bus.add, bus.busy, bus.done, bus.freq);
        end
        set_cfg(5, 7, 1, 1, 1'b0);
        bus.start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
            e_add  = (k <= 3);
            e_freq = (k <= 3) ? (4 + k) : 7;
            e_busy = (k < 4);
            e_done = (k == 4);
            n_tests++;
            if ({bus.add, bus.busy, bus.done, bus.freq} !== {e_add, e_busy, e_done, FW'(e_freq)}) begin
                n_fail++;
                $display("FAIL clean_after_reset k=%0d got add=%0b busy=%0b done=%0b freq=%0d, required add=%0b busy=%0b done=%0b freq=%0d",
                         k, bus.add, bus.busy, bus.done, bus.freq, e_add, e_busy, e_done, e_freq);
            end
        end
    endtask

    initial begin
        test_reset;
        test_up_sweep;
        tick;
        test_start_abort_idle;
        test_down_clamp;
        tick;
        test_overflow;
        tick;
        test_step_zero;
        tick;
        test_equal_start_stop;
        tick;
        test_repeat;
        test_abort_ignored_start;
        tick;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
